// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues 16-bit commands and issues them one at a time to the
// remote transmitter, retiring each on ACK with bounded retry and timeout.
module cmd_sequencer #(
   parameter int         DEPTH     = 4,
   parameter int         TIMEOUT   = 100000,
   parameter int         MAX_RETRY = 2,
   parameter logic [7:0] ACK       = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_cmd,
   input  logic [15:0] cmd_in,
   output logic        full,
   output logic        empty,
   output logic [15:0] cmd,
   output logic        send_cmd,
   input  logic        cmd_sent,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        busy,
   output logic [7:0]  ack_cnt,
   output logic        err,
   input  logic        clr_err,
   output logic [15:0] err_cmd
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int RW = $clog2(MAX_RETRY + 2);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRY);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LAUNCH    = 2'd1;
   localparam logic [1:0] WAIT_SENT = 2'd2;
   localparam logic [1:0] WAIT_RESP = 2'd3;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic          sent_mask;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry;
   logic          push;
   logic          pop;
   logic          ack_hit;
   logic          fail;
   logic          give_up;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign cmd      = mem[rd_ptr];
   assign send_cmd = (state == LAUNCH);
   assign busy     = (state != IDLE);
   assign push     = wr_cmd && !full;

   // A response in the timeout cycle wins over the timeout.
   always_comb begin
      ack_hit = 1'b0;
      fail    = 1'b0;
      if (state == WAIT_RESP) begin
         if (resp_rdy) begin
            ack_hit = (resp == ACK);
            fail    = (resp != ACK);
         end else begin
            fail = (timer == T_LAST);
         end
      end
   end

   assign give_up = fail && !(retry < R_MAX);
   assign pop     = ack_hit || give_up;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:      if (!empty) state_nx = LAUNCH;
         LAUNCH:    state_nx = WAIT_SENT;
         WAIT_SENT: if (!sent_mask && cmd_sent) state_nx = WAIT_RESP;
         WAIT_RESP: begin
            if (pop)       state_nx = IDLE;
            else if (fail) state_nx = LAUNCH;
         end
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cmd_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (!push && pop) count <= count - (AW+1)'(1);
      end
   end

   // The transmitter drops cmd_sent one cycle late, so mask it right after LAUNCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sent_mask <= 1'b0;
         timer     <= '0;
         retry     <= '0;
      end else begin
         state     <= state_nx;
         sent_mask <= (state == LAUNCH);
         if (state == WAIT_RESP) timer <= timer + TW'(1);
         else                    timer <= '0;
         if (state == IDLE)            retry <= '0;
         else if (fail && !give_up)    retry <= retry + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_cnt <= '0;
         err     <= 1'b0;
         err_cmd <= '0;
      end else begin
         if (ack_hit) ack_cnt <= ack_cnt + 8'd1;
         if (give_up) begin
            err     <= 1'b1;
            err_cmd <= cmd;
         end else if (clr_err) begin
            err <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: single ack, FIFO fill, retry, drop,
// timeout boundary and mid-transaction reset.
module tb_cmd_sequencer;
   logic        clk;
   logic        rst_n;
   logic        wr_cmd;
   logic [15:0] cmd_in;
   logic        full;
   logic        empty;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
   logic        busy;
   logic [7:0]  ack_cnt;
   logic        err;
   logic        clr_err;
   logic [15:0] err_cmd;

   int checks;
   int errors;
   int sends;
   logic [15:0] sent_log[$];

   cmd_sequencer #(
      .DEPTH(4), .TIMEOUT(50), .MAX_RETRY(2), .ACK(8'hA5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_cmd(wr_cmd), .cmd_in(cmd_in),
      .full(full), .empty(empty), .cmd(cmd), .send_cmd(send_cmd),
      .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
      .busy(busy), .ack_cnt(ack_cnt), .err(err), .clr_err(clr_err),
      .err_cmd(err_cmd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // send monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (!rst_n) begin
         sends = 0;
         sent_log.delete();
      end else if (send_cmd) begin
         sends = sends + 1;
         sent_log.push_back(cmd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      wr_cmd = 1'b0; cmd_in = '0; cmd_sent = 1'b0;
      resp_rdy = 1'b0; resp = '0; clr_err = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push(input logic [15:0] v);
      wr_cmd = 1'b1;
      cmd_in = v;
      tick();
      wr_cmd = 1'b0;
   endtask

   // Called in the LAUNCH cycle; cmd_sent rises 30 cycles after send_cmd
   // and stays stale-high for one cycle after the next send_cmd.
   task automatic transact(input logic [7:0] v);
      repeat (2) tick();
      cmd_sent = 1'b0;
      repeat (28) tick();
      cmd_sent = 1'b1;
      tick();
      resp_rdy = 1'b1;
      resp = v;
      tick();
      resp_rdy = 1'b0;
   endtask

   task automatic timeout_round(output int waited);
      repeat (2) tick();
      cmd_sent = 1'b0;
      repeat (28) tick();
      cmd_sent = 1'b1;
      tick();
      waited = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         waited = i;
         if (send_cmd || err) break;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (send_cmd !== 1'b0) begin errors++;
         $display("FAIL rst_send: got %b want 0", send_cmd); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (full !== 1'b0) begin errors++;
         $display("FAIL rst_full: got %b want 0", full); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL rst_empty: got %b want 1", empty); end
      checks++; if (ack_cnt !== 8'd0) begin errors++;
         $display("FAIL rst_ack: got %0d want 0", ack_cnt); end
      checks++; if (err !== 1'b0) begin errors++;
         $display("FAIL rst_err: got %b want 0", err); end
      checks++; if (err_cmd !== 16'h0) begin errors++;
         $display("FAIL rst_err_cmd: got %h want 0000", err_cmd); end
   endtask

   task automatic test_single();
      do_reset();
      push(16'h2345);
      checks++; if (send_cmd !== 1'b0) begin errors++;
         $display("FAIL one_early: got %b want 0", send_cmd); end
      checks++; if (empty !== 1'b0) begin errors++;
         $display("FAIL one_empty: got %b want 0", empty); end
      tick();
      checks++; if (send_cmd !== 1'b1) begin errors++;
         $display("FAIL one_latency: got %b want 1", send_cmd); end
      checks++; if (cmd !== 16'h2345) begin errors++;
         $display("FAIL one_cmd: got %h want 2345", cmd); end
      transact(8'hA5);
      repeat (3) tick();
      checks++; if (ack_cnt !== 8'd1) begin errors++;
         $display("FAIL one_ack: got %0d want 1", ack_cnt); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL one_empty2: got %b want 1", empty); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL one_busy: got %b want 0", busy); end
      checks++; if (err !== 1'b0) begin errors++;
         $display("FAIL one_err: got %b want 0", err); end
      checks++; if (sends !== 1) begin errors++;
         $display("FAIL one_sends: got %0d want 1", sends); end
   endtask

   task automatic test_fill();
      logic [15:0] exp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wr_cmd = 1'b1;
         cmd_in = 16'h1001 + 16'(i);
         tick();
         if (i == 2) begin
            checks++; if (full !== 1'b0) begin errors++;
               $display("FAIL fill_3: got %b want 0", full); end
         end
         if (i == 3) begin
            checks++; if (full !== 1'b1) begin errors++;
               $display("FAIL fill_4: got %b want 1", full); end
         end
      end
      wr_cmd = 1'b0;
      checks++; if (full !== 1'b1) begin errors++;
         $display("FAIL fill_5: got %b want 1", full); end
      cmd_sent = 1'b1;
      tick();
      resp_rdy = 1'b1;
      resp = 8'hA5;
      tick();
      resp_rdy = 1'b0;
      checks++; if (full !== 1'b0) begin errors++;
         $display("FAIL fill_pop: got %b want 0", full); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (send_cmd !== 1'b1) begin errors++;
            $display("FAIL fill_next%0d: got %b want 1", i, send_cmd); end
         transact(8'hA5);
      end
      repeat (3) tick();
      checks++; if (ack_cnt !== 8'd4) begin errors++;
         $display("FAIL fill_ack: got %0d want 4", ack_cnt); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL fill_empty: got %b want 1", empty); end
      checks++; if (sends !== 4) begin errors++;
         $display("FAIL fill_sends: got %0d want 4", sends); end
      if (sent_log.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            exp = 16'h1001 + 16'(i);
            checks++; if (sent_log[i] !== exp) begin errors++;
               $display("FAIL fill_order%0d: got %h want %h", i, sent_log[i], exp); end
         end
      end
   endtask

   task automatic test_retry();
      do_reset();
      push(16'h4ABC);
      tick();
      transact(8'h5A);
      checks++; if (send_cmd !== 1'b1) begin errors++;
         $display("FAIL retry_1: got %b want 1", send_cmd); end
      transact(8'h5A);
      checks++; if (send_cmd !== 1'b1) begin errors++;
         $display("FAIL retry_2: got %b want 1", send_cmd); end
      transact(8'hA5);
      repeat (3) tick();
      checks++; if (sends !== 3) begin errors++;
         $display("FAIL retry_sends: got %0d want 3", sends); end
      foreach (sent_log[i]) begin
         checks++; if (sent_log[i] !== 16'h4ABC) begin errors++;
            $display("FAIL retry_cmd%0d: got %h want 4abc", i, sent_log[i]); end
      end
      checks++; if (ack_cnt !== 8'd1) begin errors++;
         $display("FAIL retry_ack: got %0d want 1", ack_cnt); end
      checks++; if (err !== 1'b0) begin errors++;
         $display("FAIL retry_err: got %b want 0", err); end
   endtask

   task automatic test_drop();
      do_reset();
      push(16'h7777);
      tick();
      transact(8'h00);
      transact(8'h00);
      checks++; if (err !== 1'b0) begin errors++;
         $display("FAIL drop_early: got %b want 0", err); end
      transact(8'h00);
      checks++; if (err !== 1'b1) begin errors++;
         $display("FAIL drop_err: got %b want 1", err); end
      checks++; if (err_cmd !== 16'h7777) begin errors++;
         $display("FAIL drop_cmd: got %h want 7777", err_cmd); end
      checks++; if (ack_cnt !== 8'd0) begin errors++;
         $display("FAIL drop_ack: got %0d want 0", ack_cnt); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL drop_empty: got %b want 1", empty); end
      repeat (3) tick();
      checks++; if (sends !== 3) begin errors++;
         $display("FAIL drop_sends: got %0d want 3", sends); end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      checks++; if (err !== 1'b0) begin errors++;
         $display("FAIL drop_clr: got %b want 0", err); end
   endtask

   task automatic test_timeout();
      int waited;
      do_reset();
      push(16'h0F0F);
      tick();
      for (int r = 0; r < 3; r++) begin
         timeout_round(waited);
         checks++; if (waited !== 50) begin errors++;
            $display("FAIL tmo_wait%0d: got %0d want 50", r, waited); end
         if (r < 2) begin
            checks++; if (send_cmd !== 1'b1) begin errors++;
               $display("FAIL tmo_resend%0d: got %b want 1", r, send_cmd); end
         end
      end
      checks++; if (err !== 1'b1) begin errors++;
         $display("FAIL tmo_err: got %b want 1", err); end
      checks++; if (err_cmd !== 16'h0F0F) begin errors++;
         $display("FAIL tmo_cmd: got %h want 0f0f", err_cmd); end
      // ack arriving in the timeout cycle
      do_reset();
      push(16'h0F0F);
      tick();
      repeat (2) tick();
      cmd_sent = 1'b0;
      repeat (28) tick();
      cmd_sent = 1'b1;
      tick();
      repeat (49) tick();
      resp_rdy = 1'b1;
      resp = 8'hA5;
      tick();
      resp_rdy = 1'b0;
      checks++; if (send_cmd !== 1'b0) begin errors++;
         $display("FAIL edge_send: got %b want 0", send_cmd); end
      checks++; if (ack_cnt !== 8'd1) begin errors++;
         $display("FAIL edge_ack: got %0d want 1", ack_cnt); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL edge_busy: got %b want 0", busy); end
      repeat (3) tick();
      checks++; if (sends !== 1) begin errors++;
         $display("FAIL edge_sends: got %0d want 1", sends); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push(16'hAAA1);
      push(16'hAAA2);
      push(16'hAAA3);
      cmd_sent = 1'b1;
      repeat (4) tick();
      checks++; if (busy !== 1'b1) begin errors++;
         $display("FAIL mid_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      cmd_sent = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL mid_busy0: got %b want 0", busy); end
      checks++; if (empty !== 1'b1) begin errors++;
         $display("FAIL mid_empty: got %b want 1", empty); end
      checks++; if (send_cmd !== 1'b0) begin errors++;
         $display("FAIL mid_send: got %b want 0", send_cmd); end
      checks++; if (ack_cnt !== 8'd0) begin errors++;
         $display("FAIL mid_ack: got %0d want 0", ack_cnt); end
      rst_n = 1'b1;
      tick();
      resp_rdy = 1'b1;
      resp = 8'hA5;
      tick();
      resp_rdy = 1'b0;
      tick();
      checks++; if (ack_cnt !== 8'd0) begin errors++;
         $display("FAIL mid_spur: got %0d want 0", ack_cnt); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL mid_idle: got %b want 0", busy); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      wr_cmd = 1'b0; cmd_in = '0; cmd_sent = 1'b0;
      resp_rdy = 1'b0; resp = '0; clr_err = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_retry();
      test_drop();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Queues 16-bit commands from upstream logic and issues them one at a time to the remote command transmitter (2-byte UART command path).
- Waits for the 8-bit response after each command; acknowledge byte 0xA5 retires the command.
- A non-ack response or a response timeout triggers a bounded number of retries, then drops the command and flags an error.
- Sits between the test/host command source and the remote comm block.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- TIMEOUT, 100000, clk cycles allowed from cmd_sent to resp_rdy.
- MAX_RETRY, 2, resends allowed after the first attempt.
- ACK, 8'hA5, response value meaning success.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_cmd  in  1  push cmd_in into FIFO this cycle.
- cmd_in  in  16  command to queue.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- cmd  out  16  FIFO head, to the transmitter's cmd input.
- send_cmd  out  1  one-cycle pulse to start transmission of cmd.
- cmd_sent  in  1  transmitter status: both bytes sent (level, cleared by send_cmd).
- resp_rdy  in  1  response byte valid.
- resp  in  8  response byte.
- busy  out  1  state != IDLE.
- ack_cnt  out  8  count of acked commands, wraps 255→0.
- err  out  1  sticky: a command was dropped.
- clr_err  in  1  clears err.
- err_cmd  out  16  last dropped command.

Behaviour:
- Reset: FIFO emptied (rd/wr pointers 0, count 0), state IDLE. Outputs after reset:
  - send_cmd=0, busy=0, full=0, empty=1
  - ack_cnt=0, err=0, err_cmd=0, retry count=0, timer=0
  - cmd reflects the head entry and is don't-care while empty.
- FIFO:
  - The count register has width clog2(DEPTH)+1.
  - wr_cmd while full is dropped, even if a pop occurs in the same cycle.
  - wr_cmd and pop in the same cycle when not full: count unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd is combinational from mem[rd_ptr].
  - A write to an empty FIFO is visible on cmd the next cycle.
- State machine: IDLE, LAUNCH, WAIT_SENT, WAIT_RESP.
  - IDLE: if !empty → LAUNCH; retry count cleared.
  - LAUNCH: assert send_cmd for exactly 1 cycle → WAIT_SENT.
  - WAIT_SENT: the cycle after LAUNCH, cmd_sent is ignored, because the transmitter clears it a cycle late. From the 2nd cycle, cmd_sent=1 → WAIT_RESP with timer cleared.
  - WAIT_RESP: timer increments each cycle.
    - resp_rdy && resp==ACK: pop, ack_cnt+1 → IDLE.
    - resp_rdy && resp!=ACK, or timer==TIMEOUT-1: failure.
- Failure handling:
  - If retry count < MAX_RETRY: retry+1 → LAUNCH, same head, no pop.
  - Otherwise: pop, err=1, err_cmd=head → IDLE.
  - resp_rdy and timeout in the same cycle: resp_rdy takes priority.
- Latency:
  - wr_cmd into an empty, idle block → send_cmd asserted 2 cycles later (write cycle+1 IDLE, +2 LAUNCH).
  - Ack → next send_cmd 2 cycles later if the FIFO is non-empty.
- resp_rdy outside WAIT_RESP is ignored; no state change, no count.
- err: set takes priority over clr_err in the same cycle.
- cmd stays stable from LAUNCH until the pop, so the transmitter may sample it late.
- Reset asserted mid-transaction: immediate return to IDLE, queue discarded, send_cmd=0. There is no recovery of an in-flight command.

Test Plan:
- Reset, push 0x2345; model the transmitter (cmd_sent 30 cycles after send_cmd) and return resp 0xA5 → exactly one send_cmd, 2 cycles after the push, with cmd=0x2345; then ack_cnt=1, empty=1, busy=0, err=0.
- Push 5 commands 0x1001..0x1005 back-to-back with DEPTH=4 and a stalled transmitter → full=1 after 4 pushes, 0x1005 dropped. Ack all → sent in order 0x1001..0x1004, ack_cnt=4.
- Push 0x4ABC; respond 0x5A, 0x5A, then 0xA5 → send_cmd pulses 3 times, all with cmd=0x4ABC; ack_cnt=1, err=0.
- Push 0x7777; respond 0x00 three times (MAX_RETRY=2) → 3 sends, then err=1, err_cmd=0x7777, ack_cnt=0, empty=1. Pulse clr_err → err=0.
- TIMEOUT=50; push 0x0F0F; assert cmd_sent with no response → resend after exactly 50 cycles in WAIT_RESP; after 3 total timeouts, err=1. Separately, resp_rdy=1 with 0xA5 on cycle 49 → treated as ack, no retry.
- Reset asserted during WAIT_RESP with 3 entries queued → next cycle busy=0, empty=1, send_cmd=0, ack_cnt=0. A spurious resp_rdy=1 with 0xA5 afterwards → ack_cnt stays 0.
